// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the shared single-port byte memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to requester 0.
module mem_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            we0,
  input  logic            len0,
  input  logic [AW-1:0]   addr0,
  input  logic [2*DW-1:0] wdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic            len1,
  input  logic [AW-1:0]   addr1,
  input  logic [2*DW-1:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [2*DW-1:0] rdata0,
  output logic [2*DW-1:0] rdata1,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } state_t;

  state_t state;

  logic            owner;
  logic            curWe;
  logic            curLen;
  logic [AW-1:0]   curAddr;
  logic [2*DW-1:0] curWdata;
  logic [DW-1:0]   loByte;

  logic            anyReq;
  logic            pick;
  logic            arbNow;
  logic            finishNow;
  logic            selWe;
  logic            selLen;
  logic [AW-1:0]   selAddr;
  logic [2*DW-1:0] selWdata;
  logic [2*DW-1:0] word;

  assign anyReq = req0 | req1;
  assign arbNow = (state == IDLE) || (state == DONE);
  assign finishNow = (state == BEAT1) ||
                     ((state == BEAT0) && !curLen);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // lastGnt remembers the most recent winner; a tie goes to the other one
  logic lastGnt;

  assign pick = req1 & (~req0 | ~lastGnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGnt <= 1'b1;
    end else if (arbNow && anyReq) begin
      lastGnt <= pick;
    end
  end
`else
  assign pick = req1 & ~req0;
`endif

  assign selWe    = pick ? we1    : we0;
  assign selLen   = pick ? len1   : len0;
  assign selAddr  = pick ? addr1  : addr0;
  assign selWdata = pick ? wdata1 : wdata0;

  // Memory read data is combinational on the registered address
  assign word = (state == BEAT1) ?
                {mem_rdata, loByte} :
                {{DW{1'b0}}, mem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      curWe     <= 1'b0;
      curLen    <= 1'b0;
      curAddr   <= '0;
      curWdata  <= '0;
      loByte    <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (anyReq) begin
            state     <= BEAT0;
            owner     <= pick;
            curWe     <= selWe;
            curLen    <= selLen;
            curAddr   <= selAddr;
            curWdata  <= selWdata;
            gnt0      <= ~pick;
            gnt1      <= pick;
            mem_addr  <= selAddr;
            mem_wdata <= selWdata[DW-1:0];
            mem_we    <= selWe;
          end else begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
          end
        end
        BEAT0: begin
          if (!curWe) begin
            loByte <= mem_rdata;
          end
          if (curLen) begin
            state     <= BEAT1;
            mem_addr  <= curAddr + AW'(1);
            mem_wdata <= curWdata[2*DW-1:DW];
            mem_we    <= curWe;
          end else begin
            state     <= DONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
          end
        end
        BEAT1: begin
          state     <= DONE;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      done0 <= finishNow & ~owner;
      done1 <= finishNow & owner;
      if (finishNow && !curWe) begin
        if (owner) begin
          rdata1 <= word;
        end else begin
          rdata0 <= word;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port 8-bit × 8192 memory of the multi-cycle CPU. It shares the one memory port between instruction fetch (requester 0) and data access (requester 1). Each granted request is one or two bytes, sequenced as consecutive memory cycles. The memory's read data is combinational; its write is synchronous.

## Interface
Parameters:
- `AW`, 13, memory address width; address space is 2^AW bytes.
- `DW`, 8, memory data width; requester word is 2·DW.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request; held high until the matching `gnt`.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `len0` / `len1`  in  1  0 = one byte, 1 = two bytes.
- `addr0` / `addr1`  in  AW  start byte address.
- `wdata0` / `wdata1`  in  2·DW  write data; low byte goes to `addr`, high byte to `addr+1`.
- `gnt0` / `gnt1`  out  1  one-cycle pulse; the request has been latched.
- `done0` / `done1`  out  1  one-cycle pulse; the access is complete.
- `rdata0` / `rdata1`  out  2·DW  read result; valid from `done` onward and held until the next read completes for that requester.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  DW  memory combinational read data.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- Arbitration is evaluated in IDLE and DONE only.
  - If any `req` is high at the edge, the winner's `we`, `len`, `addr` and `wdata` are latched and the state goes to BEAT0.
  - Otherwise the state goes to (or stays in) IDLE.
- BEAT0:
  - Drives `mem_addr`=latched addr, `mem_wdata`=wdata[DW-1:0] and `mem_we`=latched we.
  - On a read, `mem_rdata` is captured into the low byte of the result.
  - Next state is BEAT1 if len=1, otherwise DONE.
- BEAT1:
  - Drives `mem_addr`=(addr+1) mod 2^AW; 8191 wraps to 0.
  - Drives `mem_wdata`=wdata[2·DW-1:DW]; on a read, the high byte is captured.
  - Next state is DONE.
- DONE:
  - Pulses the winner's `done`.
  - On a read, the captured word is transferred to the winner's `rdata`. A one-byte read returns high byte 0x00.
  - `rdata` is unchanged on a write.
  - Arbitrates for the next access in the same cycle.
- `gntX` is high during BEAT0 of requester X's access. The requester deasserts `req` at the edge ending that cycle. If `req` is still high in DONE, it is treated as a new request.
- `mem_we`=0, `mem_addr`=0 and `mem_wdata`=0 in IDLE and DONE.
- Only one requester is ever granted; grants are never preempted mid-access.
- Requester input changes after `gnt` have no effect on the access in flight.

## Timing
- Reset values: state IDLE; all `gnt`, `done` and `mem_we` = 0; `mem_addr` = 0; `mem_wdata` = 0; `rdata0` = `rdata1` = 0; round-robin pointer = 1.
- With `req` sampled at edge E0:
  - `gnt` is high in cycle E0..E1.
  - `done` is high in cycle E1..E2 for len=0, or E2..E3 for len=1.
- Back-to-back throughput: one access per 2 cycles (len=0) or 3 cycles (len=1), with no IDLE gap when requests are pending.
- Writes commit at the edge ending each beat cycle.
- Reset mid-access:
  - The access is abandoned and no `done` is issued.
  - A write beat coincident with the reset edge is not guaranteed.
  - The requester reissues the request.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Simultaneous requests go to the requester not granted most recently.
  - The pointer updates on each grant; after reset, requester 0 wins the first tie.
- Undefined: fixed priority, requester 0 (fetch) always wins ties, and the pointer logic is absent.
- A lone request is granted immediately in both modes.

## Test plan
- Memory preloaded with mem[1000]=0x1A. req0, read, len=0, addr=1000 at E0 → gnt0 high in cycle E0..E1, done0 high in cycle E1..E2, rdata0=0x001A.
- Memory preloaded with mem[0]=0xE0, mem[1]=0x43. req1, read, len=1, addr=0 → mem_addr=0 then 1, done1 in the third cycle, rdata1=0x43E0.
- Wrap-around: req1, write, len=1, addr=8191, wdata=0xBEEF → mem[8191]=0xEF, mem[0]=0xBE, then done1. A following read of 8191 (len=1) returns 0xBEEF.
- Simultaneous req0/req1 held for 4 accesses:
  - With `MEM_ARB_ROUND_ROBIN_EN`, grants go 0,1,0,1 with no IDLE gaps.
  - Without it, req0 wins every tie.
- Reset asserted during BEAT1 of a 2-byte read → next cycle: IDLE, no done, all outputs at reset values. A re-request then completes normally.
